instr_mem_loadable: RTL and testbench

Synchronous, parametrised instruction memory for the pipeline's IF stage, with a byte-serial program-load port driven by the debug unit (UART path). A program is streamed in as bytes, packed big-endian into words and written sequentially from word 0. After the load, the fetch port serves byte-addressed PCs with one-cycle registered latency and stall support. Memory contents survive reset, so a loaded program can be re-run without reloading.

---
 rtl/instr_mem_loadable_pkg.sv | 8 +
 rtl/instr_mem_loadable_if.sv | 27 ++
 rtl/instr_mem_loadable_loader.sv | 75 +++++++
 rtl/instr_mem_loadable.sv | 53 +++++
 tb/tb_instr_mem_loadable.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_loadable_pkg.sv
// imem_pkg: loader FSM states, the fetch NOP word and the word/byte geometry helper.
package imem_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    localparam logic [31:0] NOP = 32'h0000_0000;
    function automatic int bytes_per_word(input int word_width);
        return word_width / 8;
    endfunction
endpackage

// File: rtl/instr_mem_loadable_if.sv
// instr_mem_loadable_if: fetch port plus byte-serial program-load port of the instruction memory.
interface instr_mem_loadable_if #(
    parameter int MEM_SIZE    = 1024,
    parameter int WORD_WIDTH  = 32,
    parameter int ADDR_LENGTH = 32
);
    logic                      i_Fetch_en;
    logic [ADDR_LENGTH-1:0]    i_Addr;
    logic [WORD_WIDTH-1:0]     o_Data;
    logic                      o_Addr_err;
    logic                      i_Load_start;
    logic                      i_Byte_valid;
    logic [7:0]                i_Byte;
    logic                      i_Load_end;
    logic                      o_Load_busy;
    logic                      o_Load_done;
    logic [$clog2(MEM_SIZE):0] o_Word_count;
    logic                      o_Overflow;
    modport master (
        output i_Fetch_en, i_Addr, i_Load_start, i_Byte_valid, i_Byte, i_Load_end,
        input  o_Data, o_Addr_err, o_Load_busy, o_Load_done, o_Word_count, o_Overflow
    );
    modport slave (
        input  i_Fetch_en, i_Addr, i_Load_start, i_Byte_valid, i_Byte, i_Load_end,
        output o_Data, o_Addr_err, o_Load_busy, o_Load_done, o_Word_count, o_Overflow
    );
endinterface

// File: rtl/instr_mem_loadable_loader.sv
// imem_loader: load FSM that packs streamed bytes big-endian into words and writes them from word 0.
module imem_loader
    import imem_pkg::*;
#(
    parameter int   MEM_SIZE   = 1024,
    parameter int   WORD_WIDTH = 32,
    localparam int  AW         = $clog2(MEM_SIZE),
    localparam int  WCW        = $clog2(MEM_SIZE) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_Load_start,
    input  logic                  i_Byte_valid,
    input  logic [7:0]            i_Byte,
    input  logic                  i_Load_end,
    output logic                  o_we,
    output logic [AW-1:0]         o_waddr,
    output logic [WORD_WIDTH-1:0] o_wdata,
    output logic                  o_Load_busy,
    output logic                  o_Load_done,
    output logic [WCW-1:0]        o_Word_count,
    output logic                  o_Overflow
);
    localparam int BPW = bytes_per_word(WORD_WIDTH);
    localparam int BCW = $clog2(BPW + 1);
    state_t                r_state, w_state_n;
    logic [BCW-1:0]        r_bcnt, w_bcnt;
    logic [WORD_WIDTH-1:0] r_wbuf, w_wbuf;
    logic [WCW-1:0]        r_wptr;
    logic                  r_ovf;
    logic                  w_load, w_full, w_take;
    // A start pulse outranks everything else in its cycle, so bytes/end arriving with it are ignored.
    always_comb begin
        w_load    = r_state == LOAD && !i_Load_start;
        w_full    = r_wptr == WCW'(MEM_SIZE);
        w_take    = w_load && i_Byte_valid && !w_full;
        w_bcnt    = r_bcnt + BCW'(w_take);
        w_wbuf    = w_take ? r_wbuf | (WORD_WIDTH'(i_Byte) << (WORD_WIDTH - 8 - 8 * int'(r_bcnt))) : r_wbuf;
        o_we      = w_bcnt == BCW'(BPW) || (w_load && i_Load_end && w_bcnt != '0);
        w_state_n = i_Load_start ? LOAD :
                    (r_state == LOAD && i_Load_end) ? DONE :
                    (r_state == LOAD) ? LOAD : IDLE;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
            r_bcnt  <= '0;
            r_wbuf  <= '0;
            r_wptr  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (i_Load_start) begin
                r_bcnt <= '0;
                r_wbuf <= '0;
                r_wptr <= '0;
                r_ovf  <= 1'b0;
            end else if (o_we) begin
                r_bcnt <= '0;
                r_wbuf <= '0;
                r_wptr <= r_wptr + 1'b1;
            end else if (w_take) begin
                r_bcnt <= w_bcnt;
                r_wbuf <= w_wbuf;
            end
            if (w_load && i_Byte_valid && w_full) r_ovf <= 1'b1;
        end
    end
    assign o_waddr      = r_wptr[AW-1:0];
    assign o_wdata      = w_wbuf;
    assign o_Load_busy  = r_state == LOAD;
    assign o_Load_done  = r_state == DONE;
    assign o_Word_count = r_wptr;
    assign o_Overflow   = r_ovf;
endmodule

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: word memory with byte-serial program load and a registered, stallable fetch port.
module instr_mem_loadable
    import imem_pkg::*;
#(
    parameter int    MEM_SIZE    = 1024,
    parameter int    WORD_WIDTH  = 32,
    parameter int    ADDR_LENGTH = 32,
    parameter string INIT_FILE   = ""
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    instr_mem_loadable_if.slave  bus
);
    localparam int AW = $clog2(MEM_SIZE);
    logic [WORD_WIDTH-1:0] r_mem [MEM_SIZE];
    logic [WORD_WIDTH-1:0] r_data, w_wdata;
    logic [AW-1:0]         w_waddr, w_idx;
    logic                  r_err, w_err, w_we;
    imem_loader #(.MEM_SIZE(MEM_SIZE), .WORD_WIDTH(WORD_WIDTH)) u_loader (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_Load_start (bus.i_Load_start),
        .i_Byte_valid (bus.i_Byte_valid),
        .i_Byte       (bus.i_Byte),
        .i_Load_end   (bus.i_Load_end),
        .o_we         (w_we),
        .o_waddr      (w_waddr),
        .o_wdata      (w_wdata),
        .o_Load_busy  (bus.o_Load_busy),
        .o_Load_done  (bus.o_Load_done),
        .o_Word_count (bus.o_Word_count),
        .o_Overflow   (bus.o_Overflow)
    );
    // The array is deliberately outside reset so a loaded program survives it.
    always_ff @(posedge i_clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end
    assign w_idx = bus.i_Addr[2 +: AW];
    assign w_err = bus.i_Addr[1:0] != 2'b00 || (bus.i_Addr >> 2) >= ADDR_LENGTH'(MEM_SIZE);
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data <= WORD_WIDTH'(NOP);
            r_err  <= 1'b0;
        end else if (bus.o_Load_busy || bus.o_Load_done) begin
            r_data <= WORD_WIDTH'(NOP);
        end else if (bus.i_Fetch_en) begin
            r_data <= w_err ? WORD_WIDTH'(NOP) : r_mem[w_idx];
            r_err  <= w_err;
        end
    end
    assign bus.o_Data     = r_data;
    assign bus.o_Addr_err = r_err;
endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb_instr_mem_loadable: scoreboard bench driving a 1024-word and a 4-word memory with identical stimulus.
module tb_instr_mem_loadable;
    logic clk = 1'b0;
    logic rst;
    logic fetch_en, load_start, byte_valid, load_end;
    logic [31:0] addr;
    logic [7:0]  byte_v;
    always #5 clk = ~clk;

    instr_mem_loadable_if #(.MEM_SIZE(1024)) ib ();
    instr_mem_loadable_if #(.MEM_SIZE(4))    ism ();
    assign ib.i_Fetch_en    = fetch_en;
    assign ib.i_Addr        = addr;
    assign ib.i_Load_start  = load_start;
    assign ib.i_Byte_valid  = byte_valid;
    assign ib.i_Byte        = byte_v;
    assign ib.i_Load_end    = load_end;
    assign ism.i_Fetch_en   = fetch_en;
    assign ism.i_Addr       = addr;
    assign ism.i_Load_start = load_start;
    assign ism.i_Byte_valid = byte_valid;
    assign ism.i_Byte       = byte_v;
    assign ism.i_Load_end   = load_end;

    instr_mem_loadable #(.MEM_SIZE(1024)) dut_b (.i_clk(clk), .i_reset(rst), .bus(ib));
    instr_mem_loadable #(.MEM_SIZE(4))    dut_s (.i_clk(clk), .i_reset(rst), .bus(ism));

    int compared = 0;
    int mismatched = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: word contents known so far, per memory size.
    logic [31:0] mb [1024];
    logic [31:0] ms [4];
    bit          kb [1024];
    bit          ks [4];
    logic [7:0]  bq [$];
    typedef struct { logic [31:0] d; logic e; bit cd; } exp_t;
    typedef struct { int wc; bit ov; } dexp_t;
    exp_t  qb [$], qs [$];
    dexp_t db [$], ds [$];
    int nloads = 0, ndone_b = 0, ndone_s = 0;

    function automatic logic [31:0] mword(input int i);
        logic [31:0] w = 0;
        for (int k = 0; k < 4; k++) w = (w << 8) | ((4 * i + k < bq.size()) ? 32'(bq[4 * i + k]) : 32'd0);
        return w;
    endfunction

    // complete: load finished by an end pulse (partial word padded); otherwise only whole words landed.
    task automatic model_load(input bit complete);
        int len = bq.size();
        int n = complete ? (len + 3) / 4 : len / 4;
        for (int i = 0; i < n && i < 1024; i++) begin mb[i] = mword(i); kb[i] = 1; end
        for (int i = 0; i < n && i < 4; i++) begin ms[i] = mword(i); ks[i] = 1; end
        if (complete) begin
            db.push_back('{(n < 1024) ? n : 1024, len > 4096});
            ds.push_back('{(n < 4) ? n : 4, len > 16});
        end
    endtask

    // Fetch monitor: one response per edge that sampled fetch_en high.
    logic pend = 1'b0;
    always @(posedge clk) pend <= fetch_en;
    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            if (qb.size() == 0) begin compared++; mismatched++; $display("FAIL fetch_b: response with empty queue"); end
            else begin
                e = qb.pop_front();
                check("fetch_err_b", 64'(ib.o_Addr_err), 64'(e.e));
                if (e.cd) check("fetch_data_b", 64'(ib.o_Data), 64'(e.d));
            end
            if (qs.size() == 0) begin compared++; mismatched++; $display("FAIL fetch_s: response with empty queue"); end
            else begin
                e = qs.pop_front();
                check("fetch_err_s", 64'(ism.o_Addr_err), 64'(e.e));
                if (e.cd) check("fetch_data_s", 64'(ism.o_Data), 64'(e.d));
            end
        end
    end

    // Load-done monitor.
    always @(negedge clk) begin
        dexp_t d;
        if (ib.o_Load_done) begin
            ndone_b++;
            if (db.size() == 0) begin compared++; mismatched++; $display("FAIL done_b: unexpected pulse"); end
            else begin
                d = db.pop_front();
                check("word_count_b", 64'(ib.o_Word_count), 64'(d.wc));
                check("overflow_b", 64'(ib.o_Overflow), 64'(d.ov));
            end
        end
        if (ism.o_Load_done) begin
            ndone_s++;
            if (ds.size() == 0) begin compared++; mismatched++; $display("FAIL done_s: unexpected pulse"); end
            else begin
                d = ds.pop_front();
                check("word_count_s", 64'(ism.o_Word_count), 64'(d.wc));
                check("overflow_s", 64'(ism.o_Overflow), 64'(d.ov));
            end
        end
    end

    task automatic fetch(input logic [31:0] a);
        exp_t e;
        fetch_en = 1; addr = a;
        e.e = a[1:0] != 0 || (a >> 2) >= 1024;
        e.d = e.e ? 32'd0 : mb[a[11:2]];
        e.cd = e.e || kb[a[11:2]];
        qb.push_back(e);
        e.e = a[1:0] != 0 || (a >> 2) >= 4;
        e.d = e.e ? 32'd0 : ms[a[3:2]];
        e.cd = e.e || ks[a[3:2]];
        qs.push_back(e);
        @(negedge clk);
        fetch_en = 0;
    endtask

    task automatic start_pulse();
        load_start = 1;
        @(negedge clk);
        load_start = 0;
        check("busy_b", 64'(ib.o_Load_busy), 64'd1);
        check("busy_s", 64'(ism.o_Load_busy), 64'd1);
    endtask

    task automatic send(input bit end_same);
        for (int i = 0; i < bq.size(); i++) begin
            while ($urandom_range(0, 3) == 0) begin byte_valid = 0; load_end = 0; @(negedge clk); end
            byte_valid = 1; byte_v = bq[i]; load_end = end_same && i == bq.size() - 1;
            @(negedge clk);
        end
        byte_valid = 0; load_end = 0;
    endtask

    task automatic do_load(input bit end_same);
        model_load(1);
        nloads++;
        start_pulse();
        send(end_same);
        if (!end_same || bq.size() == 0) begin load_end = 1; @(negedge clk); load_end = 0; end
        @(negedge clk);
    endtask

    initial begin
        rst = 1; fetch_en = 0; addr = 0; load_start = 0; byte_valid = 0; byte_v = 0; load_end = 0;
        repeat (3) @(negedge clk);
        rst = 0;
        check("rst_data_b", 64'(ib.o_Data), 64'd0);
        check("rst_err_b", 64'(ib.o_Addr_err), 64'd0);
        check("rst_busy_b", 64'(ib.o_Load_busy), 64'd0);
        check("rst_done_b", 64'(ib.o_Load_done), 64'd0);
        check("rst_wc_b", 64'(ib.o_Word_count), 64'd0);
        check("rst_ovf_b", 64'(ib.o_Overflow), 64'd0);
        check("rst_wc_s", 64'(ism.o_Word_count), 64'd0);
        check("rst_ovf_s", 64'(ism.o_Overflow), 64'd0);
        fetch(32'h0);

        bq = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04};
        do_load(0);
        fetch(32'h0); fetch(32'h4);

        bq = '{8'hAA, 8'hBB};
        do_load(1);
        fetch(32'h0); fetch(32'h4);

        bq = {};
        for (int i = 0; i < 20; i++) bq.push_back(8'(i + 8'h10));
        do_load(0);
        for (int a = 0; a <= 20; a += 4) fetch(32'(a));
        check("ovf_sticky_s", 64'(ism.o_Overflow), 64'd1);

        fetch(32'h2); fetch(32'h1000);
        fetch(32'h4);
        fetch_en = 0; addr = 32'h2;
        repeat (3) @(negedge clk);
        check("hold_data_b", 64'(ib.o_Data), 64'(mb[1]));
        check("hold_err_b", 64'(ib.o_Addr_err), 64'd0);
        check("hold_data_s", 64'(ism.o_Data), 64'(ms[1]));

        // Restart mid-load: whole words of the aborted attempt stay in memory.
        bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
        start_pulse();
        send(0);
        model_load(0);
        bq = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
        do_load(0);
        fetch(32'h0); fetch(32'h4); fetch(32'h8);

        // Reset mid-load after 6 bytes: word 0 written, word 1 keeps old contents.
        bq = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
        start_pulse();
        send(0);
        model_load(0);
        rst = 1; @(negedge clk); rst = 0;
        check("mid_rst_wc_b", 64'(ib.o_Word_count), 64'd0);
        check("mid_rst_busy_b", 64'(ib.o_Load_busy), 64'd0);
        check("mid_rst_ovf_s", 64'(ism.o_Overflow), 64'd0);
        fetch(32'h0); fetch(32'h4);

        for (int r = 0; r < 10; r++) begin
            int len = $urandom_range(1, 24);
            bq = {};
            for (int i = 0; i < len; i++) bq.push_back(8'($urandom));
            do_load(1'($urandom_range(0, 1)));
            for (int f = 0; f < 6; f++)
                fetch(($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom_range(0, 9) * 4));
        end

        repeat (3) @(negedge clk);
        check("done_count_b", 64'(ndone_b), 64'(nloads));
        check("done_count_s", 64'(ndone_s), 64'(nloads));
        check("fetch_left_b", 64'(qb.size()), 64'd0);
        check("fetch_left_s", 64'(qs.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
